// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the burst reader of the 64x8 RAM.
package ram_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 7;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(RAM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Requests longer than the address space read every word exactly once.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry show-ahead FIFO that catches read data still in flight when the
// downstream stalls.
module ram_rd_skid_buf
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              wr_ok;
    logic              rd_ok;

    // A write into a full buffer is only accepted when a pop frees a slot.
    assign wr_ok = wr_en && ((count_reg != 2'd2) || rd_en);
    assign rd_ok = rd_en && (count_reg != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_ok) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (rd_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, wr_ok} - {1'b0, rd_ok};
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: issues one RAM read per cycle and streams the returned
// bytes out with valid/ready, last-beat flag and a completion pulse.
module ram_burst_reader
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [LEN_W-1:0]  remaining_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic              inflight_reg;
    logic              done_reg;

    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf_data;
    logic [2:0]        occupancy;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_beat;

    ram_rd_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_reg),
        .wr_data (mem_rd_data),
        .rd_en   (pop),
        .rd_data (buf_data),
        .count   (buf_count)
    );

    assign out_valid = (buf_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign last_beat = out_valid && (beat_reg == len_reg - LEN_W'(1));
    assign accept    = req_valid && req_ready;

    // Slots the buffer will hold next cycle if we do not issue now; a new read
    // is only safe while at least one slot stays free for its data.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        busy       = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_len != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (remaining_reg != '0) && (occupancy <= 3'd1);
                if (issue && (remaining_reg == LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            rd_addr_reg   <= '0;
            remaining_reg <= '0;
            len_reg       <= '0;
            beat_reg      <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            done_reg     <= (accept && (req_len == '0)) ||
                            ((state_reg == DRAIN) && pop && last_beat);
            if (accept) begin
                addr_reg      <= req_addr;
                remaining_reg <= sat_len(req_len);
                len_reg       <= sat_len(req_len);
                beat_reg      <= '0;
            end
            if (issue) begin
                addr_reg      <= addr_reg + ADDR_W'(1);
                remaining_reg <= remaining_reg - LEN_W'(1);
                rd_addr_reg   <= addr_reg;
            end
            if (pop) begin
                beat_reg <= beat_reg + LEN_W'(1);
            end
        end
    end

    // The address bus shows the last issued address between reads.
    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? addr_reg : rd_addr_reg;
    assign out_data    = out_valid ? buf_data : '0;
    assign out_last    = last_beat;
    assign done        = done_reg;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a RAM model answers reads, accepted
// requests enqueue expected beats, a negedge monitor checks the stream.
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] req_addr = '0;
    logic [6:0] req_len = '0;
    logic       mem_rd_en;
    logic [5:0] mem_rd_addr;
    logic [7:0] mem_rd_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    ram_burst_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read
    logic [7:0] ram [64];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cnt = 0, acc_cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int hs_total = 0;
    int rd_cnt = 0, exp_rd = 0;
    int max_buf = 0;
    int ready_mode = 0;
    int pat_idx = 0;
    bit done_due = 0, awaiting_first = 0, stall = 0;
    logic [7:0] held_d;
    logic       held_l;
    int n_beats;
    logic [5:0] ix;
    beat_t got, want;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = always high, 1 = random, 2 = pattern 1,0,0,1,0,1
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = (pat_idx == 0 || pat_idx == 3 || pat_idx == 5);
                    pat_idx = (pat_idx + 1) % 6;
                end
            endcase
        end
    end

    // Monitor and request tracker
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_due = 0;
            awaiting_first = 0;
            stall = 0;
        end else begin
            if (int'(dut.buf_count) > max_buf) max_buf = int'(dut.buf_count);
            if (mem_rd_en) rd_cnt++;
            if (req_valid && busy) check("req_ready_while_busy", int'(req_ready), 0);

            if (done || done_due) begin
                check("done_timing", int'(done), int'(done_due));
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("reads_issued", rd_cnt, exp_rd);
                    check("queue_empty_at_done", exp_q.size(), 0);
                end
            end
            done_due = 0;

            if (stall) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(held_d));
                check("stall_last_held", int'(out_last), int'(held_l));
            end

            if (out_valid && awaiting_first) begin
                check("first_valid_latency", cyc - acc_cyc, 3);
                awaiting_first = 0;
            end

            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", int'(out_data), -1);
                end else begin
                    want = exp_q.pop_front();
                    got.d = out_data;
                    got.l = out_last;
                    check("beat_data", int'(got.d), int'(want.d));
                    check("beat_last", int'(got.l), int'(want.l));
                    if (want.l) done_due = 1;
                end
            end
            stall  = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;

            // Reference: a burst reads min(len,64) words from addr upward, wrapping at 64.
            if (req_valid && req_ready) begin
                n_beats = (int'(req_len) > 64) ? 64 : int'(req_len);
                for (int k = 0; k < n_beats; k++) begin
                    ix = req_addr + 6'(k);
                    want.d = ram[ix];
                    want.l = (k == n_beats - 1);
                    exp_q.push_back(want);
                end
                acc_cnt++;
                acc_cyc = cyc;
                exp_rd = n_beats;
                rd_cnt = 0;
                if (n_beats == 0) done_due = 1;
                else awaiting_first = 1;
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, int'({req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data,
                          out_last, busy, done}),
              int'({1'b1, 1'b0, 6'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}));
    endtask

    task automatic send_req(input int a, input int l);
        int c0;
        int i;
        c0 = acc_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 6'(a);
        req_len   = 7'(l);
        i = 0;
        while (acc_cnt == c0 && i < 400) begin
            @(posedge clk);
            i++;
        end
        check("req_accepted", int'(acc_cnt != c0), 1);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        check("done_seen", int'(done_cnt != d0), 1);
    endtask

    initial begin
        int d0;
        int h0;
        int i;
        int c0;
        for (int k = 0; k < 64; k++) ram[k] = 8'(k);

        #2;
        check_reset_outputs("reset_state");
        #20;
        rst_n = 1'b1;

        // Basic burst, full throughput
        ready_mode = 0;
        d0 = done_cnt;
        send_req(5, 4);
        wait_done(d0, 100);
        check("burst_total_cycles", done_cyc - acc_cyc, 7);

        // Address wrap
        d0 = done_cnt;
        send_req(62, 4);
        wait_done(d0, 100);

        // Backpressure pattern
        ready_mode = 2;
        d0 = done_cnt;
        send_req(30, 6);
        wait_done(d0, 200);

        // Zero length
        ready_mode = 0;
        d0 = done_cnt;
        send_req(9, 0);
        wait_done(d0, 20);
        check("zero_len_done_delay", done_cyc - acc_cyc, 1);

        // Saturated length
        d0 = done_cnt;
        send_req(17, 100);
        wait_done(d0, 300);
        check("sat_len_total_cycles", done_cyc - acc_cyc, 67);

        // Reset after three beats
        h0 = hs_total;
        d0 = done_cnt;
        send_req(20, 40);
        i = 0;
        while (hs_total < h0 + 3 && i < 100) begin
            @(posedge clk);
            i++;
        end
        check("three_beats_before_reset", int'(hs_total >= h0 + 3), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_burst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("no_done_after_abort", done_cnt, d0);
        d0 = done_cnt;
        send_req(10, 2);
        wait_done(d0, 100);

        // Request held during a burst is only taken once req_ready returns
        ready_mode = 2;
        d0 = done_cnt;
        c0 = acc_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 6'd3;
        req_len   = 7'd8;
        i = 0;
        while (acc_cnt == c0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        #1;
        req_addr = 6'd40;
        req_len  = 7'd5;
        i = 0;
        while (acc_cnt < c0 + 2 && i < 300) begin
            @(posedge clk);
            i++;
        end
        check("second_req_accepted", acc_cnt - c0, 2);
        check("second_accept_on_done", acc_cyc, done_cyc);
        check("one_done_before_second", done_cnt - d0, 1);
        #1;
        req_valid = 1'b0;
        wait_done(d0 + 1, 300);

        // Randomized bursts
        ready_mode = 1;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 64; k++) ram[k] = 8'($urandom_range(0, 255));
            d0 = done_cnt;
            send_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 80)));
            wait_done(d0, 1000);
        end

        check("buf_count_max_le_2", int'(max_buf > 2), 0);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side initiator for the team's 64x8 synchronous single-port RAM.
- Accepts a burst request (start address, length) and issues one read address per cycle to the RAM's read port.
- Returns the read data as a valid/ready byte stream, with a last-beat flag and a completion pulse.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry skid buffer, so downstream backpressure never loses data.

Parameters:
- ADDR_W, 6, RAM address width; the address space is 2**ADDR_W = 64 words.
- DATA_W, 8, RAM and stream data width.
- LEN_W, 7, request length width; this width is needed to express 64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  burst request valid.
- req_ready  output  1  ready to accept a request; high only in IDLE.
- req_addr  input  ADDR_W  burst start address.
- req_len  input  LEN_W  beats to read, 0..64.
- mem_rd_en  output  1  read strobe to RAM; marks an issued read.
- mem_rd_addr  output  ADDR_W  RAM read address.
- mem_rd_data  input  DATA_W  RAM registered read data, valid 1 cycle after issue.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream ready.
- out_data  output  DATA_W  stream data.
- out_last  output  1  marks the final beat of the burst.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; skid buffer emptied; in-flight read discarded. Outputs: req_ready=1, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on req_valid&&req_ready with req_len>=1.
  - Latch addr=req_addr and remaining=min(req_len,64); req_len>64 saturates to 64.
  - Clear beat counter.
- IDLE with req_len=0 accepted: no reads issued, no beats. done pulses in the next cycle; state stays IDLE.
- RUN issue rule: mem_rd_en=1 when remaining>0 AND (buf_count + inflight - pop) <= 1.
  - pop = out_valid&&out_ready; inflight = mem_rd_en registered.
  - Each issue increments addr modulo 64 (wraps 63 -> 0) and decrements remaining.
- Throughput: with out_ready held high, sustained 1 beat/cycle.
- Latency: request accepted in cycle T -> first mem_rd_en in T+1 -> data captured end of T+2 -> out_valid at T+3.
- RUN -> DRAIN when the last read is issued (remaining reaches 0).
- DRAIN -> IDLE on the handshake of the beat with out_last=1. done pulses in the following cycle; req_ready returns high that same cycle.
- Stream rules:
  - out_data and out_last are held stable while out_valid&&!out_ready.
  - out_valid never drops without a handshake.
  - out_last=1 only on beat number remaining_at_start-1, counting from 0.
- Skid buffer: 2-entry FIFO. Written when inflight=1 (captures mem_rd_data); popped on handshake. Simultaneous write and pop in the same cycle is legal. Overflow is impossible by the issue rule; verification asserts this.
- req_valid while busy is ignored (req_ready=0); no queuing.
- mem_rd_addr holds its last value when mem_rd_en=0.
- Reset mid-burst: immediate abort; no done pulse; RAM contents unaffected.

Decomposition:
- Package ram_pkg:
  - RAM_DEPTH=64, ADDR_W, DATA_W, LEN_W.
  - State enum {IDLE, RUN, DRAIN}.
  - MAX_LEN=64 constant.
- One sub-module, ram_rd_skid_buf: 2-entry synchronous FIFO with count output, async active-low reset, same clk/rst_n names.
- Top module holds the FSM, the address and length counters, and the issue logic.

Test Plan:
- RAM preloaded ram[i]=i; req addr=5 len=4, out_ready=1 -> beats 5,6,7,8 on consecutive cycles. First out_valid 3 cycles after acceptance; out_last on 8; done 1 cycle after the last handshake.
- Wrap: addr=62 len=4 -> beats 62,63,0,1; out_last on 1.
- Backpressure: len=6, out_ready toggled 1,0,0,1,0,1... -> all 6 bytes delivered in order, none duplicated. out_data stable while stalled; buf_count never exceeds 2.
- len=0 -> no mem_rd_en, no out_valid, single done pulse. len=100 -> exactly 64 beats.
- Reset asserted mid-burst after 3 beats -> all outputs at reset values immediately. A new request addr=10 len=2 then returns 10,11 cleanly.
- Request while busy: req_valid held during a burst -> ignored. The second request is accepted only once req_ready returns high after done.
